gpo_bank_ctrl: RTL and testbench
================================

Name: gpo_bank_ctrl

Overview:
- Multi-channel controller that drives a bank of NCH GPO pad cells.
- Registers per-channel data and output enable.
- Holds per-channel drive configuration: drive strength, slew rate, CO, and output mode (push-pull, open-drain low, open-drain high, park).
- Applies any configuration change with break-before-make sequencing: the pad is tristated for a guard window before the change and a settle window after it.
- Enforces VBIAS gating of high drive strengths. Sits between core GPIO logic and the pad ring.

Parameters:
- NCH, 8, number of GPO channels (1..32).
- GUARD_CYC, 4, cycles OE is forced low before a config change (>=1).
- SETTLE_CYC, 2, cycles OE stays low after a config change (>=0).
- CHW, $clog2(NCH) (min 1), channel index width; derived, never overridden.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset, asynchronous, active-high
- vbias_ok_i  in  1  VBIAS valid, synchronous to CLK_I
- do_i  in  NCH  per-channel data
- oe_i  in  NCH  per-channel output enable request
- cfg_valid_i  in  1  config request valid
- cfg_ready_o  out  1  config request ready
- cfg_ch_i  in  CHW  target channel
- cfg_ds_i  in  2  drive strength
- cfg_sr_i  in  1  slew rate
- cfg_co_i  in  1  CO setting
- cfg_mode_i  in  2  00 push-pull, 01 open-drain low, 10 open-drain high, 11 park
- cfg_err_o  out  1  one-cycle pulse: cfg_ch_i >= NCH
- busy_o  out  1  sequencer not IDLE
- ds_clamp_o  out  NCH  DS was clamped to 00 because VBIAS was not ok
- DO_O  out  NCH  to pad DO_I
- OE_O  out  NCH  to pad OE_I
- DS_O  out  2*NCH  to pad DS_I; channel k uses bits [2k+1:2k]
- SR_O  out  NCH  to pad SR_I
- CO_O  out  NCH  to pad CO_I
- ODP_O  out  NCH  to pad ODP_I
- ODN_O  out  NCH  to pad ODN_I

Behaviour:
- Reset values (RST_I asserted, asynchronous):
  - DO_O, OE_O, DS_O, SR_O, CO_O, ODP_O, ODN_O, ds_clamp_o, cfg_err_o, busy_o are all 0.
  - cfg_ready_o=1; FSM in IDLE; counter=0.
- Data path, 1-cycle registered latency:
  - DO_O[k] <= do_i[k].
  - OE_O[k] <= oe_i[k] & ~gate[k] & (DS[k]==00 | vbias_ok_i).
  - gate[k]=1 only while the FSM is in DRAIN/APPLY/SETTLE with target channel k.
- Mode mapping, registered:
  - 00 gives ODP=0, ODN=0.
  - 01 gives ODP=0, ODN=1 (high-side disabled).
  - 10 gives ODP=1, ODN=0.
  - 11 gives ODP=1, ODN=1 (pad high-Z).
- FSM states: IDLE, DRAIN, APPLY, SETTLE.
- IDLE:
  - cfg_ready_o=1.
  - On cfg_valid_i & cfg_ready_o with cfg_ch_i<NCH: latch the request, load counter=GUARD_CYC-1, go to DRAIN; cfg_ready_o=0 from the next cycle.
  - With cfg_ch_i>=NCH: cfg_err_o pulses next cycle, stay IDLE, no register changes.
- DRAIN:
  - gate set for the target channel.
  - Counter decrements each cycle; at 0, go to APPLY. Total GUARD_CYC cycles.
- APPLY (1 cycle):
  - Write SR, CO, mode to the target channel.
  - If cfg_ds!=00 and vbias_ok_i==0: store DS=00 and set ds_clamp_o[ch]. Otherwise store cfg_ds and clear ds_clamp_o[ch].
  - If SETTLE_CYC==0, go to IDLE; else load counter=SETTLE_CYC-1 and go to SETTLE.
- SETTLE:
  - gate still set; count down; at 0, go to IDLE.
  - OE_O[ch] resumes following oe_i on the cycle after IDLE is re-entered.
- busy_o=1 in every state except IDLE.
- Only one request is in flight at a time. Other channels are unaffected throughout and keep following do_i/oe_i.
- VBIAS loss:
  - A channel with DS!=00 gets OE_O=0 one cycle after vbias_ok_i falls and recovers one cycle after it rises.
  - Stored DS is not modified by vbias_ok_i changes outside APPLY.
- Reconfiguring with identical values still runs the full DRAIN/APPLY/SETTLE sequence.
- Reset mid-sequence: immediate return to the reset values above; the pending request is discarded.

Test Plan:
- Reset: assert RST_I with no clock edge -> all pad outputs 0, cfg_ready_o=1. Release RST_I, set oe_i=8'hFF, do_i=8'hA5 -> OE_O=8'hFF, DO_O=8'hA5 one cycle later.
- Config ch3 (ds=10, sr=1, co=1, mode=00), vbias_ok_i=1, oe_i=8'hFF, GUARD_CYC=4, SETTLE_CYC=2:
  - OE_O[3]=0 for exactly 7 cycles; other bits stay 1.
  - DS_O[7:6]=10 and SR_O[3]=1 after APPLY.
  - busy_o high 7 cycles; cfg_ready_o low 7 cycles.
- Clamp: config ch0 with ds=11 while vbias_ok_i=0 -> DS_O[1:0]=00, ds_clamp_o[0]=1. Repeat with vbias_ok_i=1 -> DS_O[1:0]=11, ds_clamp_o[0]=0.
- VBIAS drop with ch0 at DS=11, oe_i[0]=1: drop vbias_ok_i for 5 cycles -> OE_O[0]=0 for 5 cycles, offset by 1 cycle; DS_O unchanged.
- Error and modes:
  - cfg_ch_i=9 with NCH=8 -> cfg_err_o single pulse, busy_o stays 0.
  - mode=01 -> ODP_O=0, ODN_O=1; mode=11 -> both 1.
- Reset mid-DRAIN (cycle 2) -> outputs return to reset values immediately; after release, config registers are 0 and FSM is IDLE.

Source files
------------

// File: rtl/gpo_bank_ctrl.sv
// GPO pad-bank controller: registered data/OE path, per-channel drive
// config with break-before-make sequencing and VBIAS drive gating.
module gpo_bank_ctrl #(
  parameter int NCH        = 8,
  parameter int GUARD_CYC  = 4,
  parameter int SETTLE_CYC = 2,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             vbias_ok_i,
  input  logic [NCH-1:0]   do_i,
  input  logic [NCH-1:0]   oe_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CHW-1:0]   cfg_ch_i,
  input  logic [1:0]       cfg_ds_i,
  input  logic             cfg_sr_i,
  input  logic             cfg_co_i,
  input  logic [1:0]       cfg_mode_i,
  output logic             cfg_err_o,
  output logic             busy_o,
  output logic [NCH-1:0]   ds_clamp_o,
  output logic [NCH-1:0]   DO_O,
  output logic [NCH-1:0]   OE_O,
  output logic [2*NCH-1:0] DS_O,
  output logic [NCH-1:0]   SR_O,
  output logic [NCH-1:0]   CO_O,
  output logic [NCH-1:0]   ODP_O,
  output logic [NCH-1:0]   ODN_O
);

  localparam int CMAX =
    (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNTW-1:0] GUARD_LD =
    CNTW'(GUARD_CYC - 1);
  localparam logic [CNTW-1:0] SETTLE_LD =
    CNTW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CHW:0] NCH_V = (CHW + 1)'(NCH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [CHW-1:0] ch_q, ch_d;
  logic [1:0]     rds_q, rds_d;
  logic           rsr_q, rsr_d;
  logic           rco_q, rco_d;
  logic [1:0]     rmode_q, rmode_d;

  logic [NCH-1:0]   do_q, do_d;
  logic [NCH-1:0]   oe_q, oe_d;
  logic [2*NCH-1:0] ds_q, ds_d;
  logic [NCH-1:0]   sr_q, sr_d;
  logic [NCH-1:0]   co_q, co_d;
  logic [NCH-1:0]   odp_q, odp_d;
  logic [NCH-1:0]   odn_q, odn_d;
  logic [NCH-1:0]   clamp_q, clamp_d;
  logic             err_q, err_d;

  logic           ch_ok;
  logic           accept;
  logic           apply_en;
  logic           ready;
  logic [NCH-1:0] gate;

  assign ch_ok  = {1'b0, cfg_ch_i} < NCH_V;
  assign accept = cfg_valid_i & ready & ch_ok;

  // FSM: state register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = APPLY;
      end
      APPLY: begin
        state_d = (SETTLE_CYC == 0) ? IDLE : SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready    = 1'b0;
    apply_en = 1'b0;
    gate     = '0;
    unique case (state_q)
      IDLE:   ready    = 1'b1;
      APPLY:  apply_en = 1'b1;
      default: ;
    endcase
    if (!ready) begin
      for (int k = 0; k < NCH; k++) begin
        gate[k] = (ch_q == CHW'(k));
      end
    end
  end

  assign cfg_ready_o = ready;
  assign busy_o      = ~ready;

  // Guard / settle down-counter
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = GUARD_LD;
    end else if (apply_en) begin
      cnt_d = SETTLE_LD;
    end else if (!ready && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Latched request
  always_comb begin
    ch_d    = ch_q;
    rds_d   = rds_q;
    rsr_d   = rsr_q;
    rco_d   = rco_q;
    rmode_d = rmode_q;
    if (accept) begin
      ch_d    = cfg_ch_i;
      rds_d   = cfg_ds_i;
      rsr_d   = cfg_sr_i;
      rco_d   = cfg_co_i;
      rmode_d = cfg_mode_i;
    end
  end

  // Per-channel config, written only in APPLY
  always_comb begin
    ds_d    = ds_q;
    sr_d    = sr_q;
    co_d    = co_q;
    odp_d   = odp_q;
    odn_d   = odn_q;
    clamp_d = clamp_q;
    for (int k = 0; k < NCH; k++) begin
      if (apply_en && ch_q == CHW'(k)) begin
        sr_d[k]  = rsr_q;
        co_d[k]  = rco_q;
        odp_d[k] = rmode_q[1];
        odn_d[k] = rmode_q[0];
        if (rds_q != 2'b00 && !vbias_ok_i) begin
          ds_d[2*k +: 2] = 2'b00;
          clamp_d[k]     = 1'b1;
        end else begin
          ds_d[2*k +: 2] = rds_q;
          clamp_d[k]     = 1'b0;
        end
      end
    end
  end

  // Data path: high drive strengths need VBIAS to enable
  always_comb begin
    do_d = do_i;
    oe_d = '0;
    for (int k = 0; k < NCH; k++) begin
      oe_d[k] = oe_i[k] & ~gate[k] &
                ((ds_q[2*k +: 2] == 2'b00) | vbias_ok_i);
    end
  end

  assign err_d = cfg_valid_i & ready & ~ch_ok;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      rds_q   <= '0;
      rsr_q   <= 1'b0;
      rco_q   <= 1'b0;
      rmode_q <= '0;
      do_q    <= '0;
      oe_q    <= '0;
      ds_q    <= '0;
      sr_q    <= '0;
      co_q    <= '0;
      odp_q   <= '0;
      odn_q   <= '0;
      clamp_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rds_q   <= rds_d;
      rsr_q   <= rsr_d;
      rco_q   <= rco_d;
      rmode_q <= rmode_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
      ds_q    <= ds_d;
      sr_q    <= sr_d;
      co_q    <= co_d;
      odp_q   <= odp_d;
      odn_q   <= odn_d;
      clamp_q <= clamp_d;
      err_q   <= err_d;
    end
  end

  assign DO_O       = do_q;
  assign OE_O       = oe_q;
  assign DS_O       = ds_q;
  assign SR_O       = sr_q;
  assign CO_O       = co_q;
  assign ODP_O      = odp_q;
  assign ODN_O      = odn_q;
  assign ds_clamp_o = clamp_q;
  assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_gpo_bank_ctrl.sv
// Scoreboard bench for gpo_bank_ctrl: a cycle model pushes expected
// outputs per clock; they are popped and compared after the edge.
module tb_gpo_bank_ctrl;

  localparam int NCH = 8;
  localparam int G   = 4;
  localparam int S   = 2;

  typedef struct {
    logic [7:0]  dout;
    logic [7:0]  oe;
    logic [15:0] ds;
    logic [7:0]  sr;
    logic [7:0]  co;
    logic [7:0]  odp;
    logic [7:0]  odn;
    logic [7:0]  clamp;
    logic        err;
    logic        busy;
    logic        rdy;
  } exp_t;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;
  logic vb = 1'b0;
  logic [7:0] dov = '0;
  logic [7:0] oev = '0;
  logic cv = 1'b0;
  logic [2:0] cch = '0;
  logic [1:0] cds = '0;
  logic csr = 1'b0;
  logic cco = 1'b0;
  logic [1:0] cmode = '0;

  logic rdy, err, busy;
  logic [7:0] clamp, DO_O, OE_O, SR_O, CO_O, ODP_O, ODN_O;
  logic [15:0] DS_O;

  logic e_cv = 1'b0;
  logic [2:0] e_ch = '0;
  logic e_rdy, e_err, e_busy;
  logic [4:0] e_clamp, e_do, e_oe, e_sr, e_co, e_odp, e_odn;
  logic [9:0] e_ds;

  always #5 CLK_I = ~CLK_I;

  gpo_bank_ctrl #(.NCH(NCH), .GUARD_CYC(G), .SETTLE_CYC(S)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .vbias_ok_i(vb),
    .do_i(dov), .oe_i(oev),
    .cfg_valid_i(cv), .cfg_ready_o(rdy), .cfg_ch_i(cch),
    .cfg_ds_i(cds), .cfg_sr_i(csr), .cfg_co_i(cco),
    .cfg_mode_i(cmode), .cfg_err_o(err), .busy_o(busy),
    .ds_clamp_o(clamp), .DO_O(DO_O), .OE_O(OE_O), .DS_O(DS_O),
    .SR_O(SR_O), .CO_O(CO_O), .ODP_O(ODP_O), .ODN_O(ODN_O)
  );

  // Five channels: 3-bit index can express out-of-range channels
  gpo_bank_ctrl #(.NCH(5), .GUARD_CYC(G), .SETTLE_CYC(S)) u5 (
    .CLK_I(CLK_I), .RST_I(RST_I), .vbias_ok_i(vb),
    .do_i(dov[4:0]), .oe_i(oev[4:0]),
    .cfg_valid_i(e_cv), .cfg_ready_o(e_rdy), .cfg_ch_i(e_ch),
    .cfg_ds_i(cds), .cfg_sr_i(csr), .cfg_co_i(cco),
    .cfg_mode_i(cmode), .cfg_err_o(e_err), .busy_o(e_busy),
    .ds_clamp_o(e_clamp), .DO_O(e_do), .OE_O(e_oe), .DS_O(e_ds),
    .SR_O(e_sr), .CO_O(e_co), .ODP_O(e_odp), .ODN_O(e_odn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  exp_t sb[$];

  logic [15:0] m_ds;
  logic [7:0]  m_sr, m_co, m_odp, m_odn, m_clamp;
  int          m_left;
  int          m_ch;
  logic [1:0]  r_ds, r_mode;
  logic        r_sr, r_co;

  int n_oe3, n_oe0, n_busy, n_nrdy;

  task automatic m_reset();
    m_ds = '0; m_sr = '0; m_co = '0;
    m_odp = '0; m_odn = '0; m_clamp = '0;
    m_left = 0; m_ch = 0;
    r_ds = '0; r_mode = '0; r_sr = 0; r_co = 0;
  endtask

  task automatic step();
    exp_t e, g;
    logic [7:0] gt;
    gt = '0;
    if (m_left > 0) gt[m_ch] = 1'b1;
    for (int k = 0; k < NCH; k++)
      e.oe[k] = oev[k] & ~gt[k] & ((m_ds[2*k +: 2] == 2'b00) | vb);
    e.dout = dov;
    if (m_left == S + 1) begin
      m_sr[m_ch]  = r_sr;
      m_co[m_ch]  = r_co;
      m_odp[m_ch] = r_mode[1];
      m_odn[m_ch] = r_mode[0];
      if (r_ds != 2'b00 && !vb) begin
        m_ds[2*m_ch +: 2] = 2'b00;
        m_clamp[m_ch] = 1'b1;
      end else begin
        m_ds[2*m_ch +: 2] = r_ds;
        m_clamp[m_ch] = 1'b0;
      end
    end
    e.err = (m_left == 0) && cv && (int'(cch) >= NCH);
    if (m_left > 0) begin
      m_left--;
    end else if (cv && int'(cch) < NCH) begin
      m_left = G + S + 1;
      m_ch = int'(cch);
      r_ds = cds; r_sr = csr; r_co = cco; r_mode = cmode;
    end
    e.ds = m_ds; e.sr = m_sr; e.co = m_co;
    e.odp = m_odp; e.odn = m_odn; e.clamp = m_clamp;
    e.busy = (m_left > 0);
    e.rdy  = (m_left == 0);
    sb.push_back(e);
    @(posedge CLK_I);
    @(negedge CLK_I);
    g = sb.pop_front();
    chk("DO", DO_O, g.dout);
    chk("OE", OE_O, g.oe);
    chk("DS", DS_O, g.ds);
    chk("SR", SR_O, g.sr);
    chk("CO", CO_O, g.co);
    chk("ODP", ODP_O, g.odp);
    chk("ODN", ODN_O, g.odn);
    chk("clamp", clamp, g.clamp);
    chk("err", err, g.err);
    chk("busy", busy, g.busy);
    chk("ready", rdy, g.rdy);
    if (!OE_O[3]) n_oe3++;
    if (!OE_O[0]) n_oe0++;
    if (busy) n_busy++;
    if (!rdy) n_nrdy++;
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [1:0] ds,
                     input logic sr, input logic co,
                     input logic [1:0] mode);
    n_oe3 = 0; n_oe0 = 0; n_busy = 0; n_nrdy = 0;
    cch = ch; cds = ds; csr = sr; cco = co; cmode = mode;
    cv = 1'b1;
    step();
    cv = 1'b0;
    repeat (G + S + 2) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_DO"}, DO_O, 0);
    chk({tag, "_OE"}, OE_O, 0);
    chk({tag, "_DS"}, DS_O, 0);
    chk({tag, "_SR"}, SR_O, 0);
    chk({tag, "_CO"}, CO_O, 0);
    chk({tag, "_ODP"}, ODP_O, 0);
    chk({tag, "_ODN"}, ODN_O, 0);
    chk({tag, "_clamp"}, clamp, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, rdy, 1);
  endtask

  initial begin
    m_reset();
    #1 RST_I = 1'b1;
    #1 chk_reset_vals("rst");
    @(negedge CLK_I);
    RST_I = 1'b0;
    dov = 8'hA5; oev = 8'hFF; vb = 1'b1;
    step();
    chk("rst_do", DO_O, 8'hA5);
    chk("rst_oe", OE_O, 8'hFF);

    cfg(3'd3, 2'b10, 1'b1, 1'b1, 2'b00);
    chk("ch3_oe_low", n_oe3, 7);
    chk("ch3_others", OE_O, 8'hFF);
    chk("ch3_ds", DS_O[7:6], 2'b10);
    chk("ch3_sr", SR_O[3], 1'b1);
    chk("ch3_busy", n_busy, 7);
    chk("ch3_nrdy", n_nrdy, 7);

    cfg(3'd3, 2'b10, 1'b1, 1'b1, 2'b00);
    chk("same_busy", n_busy, 7);
    chk("same_oe_low", n_oe3, 7);

    vb = 1'b0;
    cfg(3'd0, 2'b11, 1'b0, 1'b1, 2'b00);
    chk("clamp_ds", DS_O[1:0], 2'b00);
    chk("clamp_flag", clamp[0], 1'b1);
    vb = 1'b1;
    cfg(3'd0, 2'b11, 1'b0, 1'b1, 2'b00);
    chk("noclamp_ds", DS_O[1:0], 2'b11);
    chk("noclamp_flag", clamp[0], 1'b0);

    n_oe0 = 0;
    vb = 1'b0;
    repeat (5) step();
    vb = 1'b1;
    repeat (2) step();
    chk("vb_oe0_low", n_oe0, 5);
    chk("vb_ds_kept", DS_O[1:0], 2'b11);

    cfg(3'd1, 2'b01, 1'b0, 1'b0, 2'b01);
    chk("m01_odp", ODP_O[1], 1'b0);
    chk("m01_odn", ODN_O[1], 1'b1);
    cfg(3'd2, 2'b00, 1'b1, 1'b0, 2'b11);
    chk("m11_odp", ODP_O[2], 1'b1);
    chk("m11_odn", ODN_O[2], 1'b1);
    cfg(3'd7, 2'b00, 1'b0, 1'b0, 2'b10);
    chk("m10_odp", ODP_O[7], 1'b1);
    chk("m10_odn", ODN_O[7], 1'b0);

    e_ch = 3'd5; e_cv = 1'b1;
    @(posedge CLK_I); @(negedge CLK_I);
    chk("e5_err", e_err, 1'b1);
    chk("e5_busy", e_busy, 1'b0);
    e_cv = 1'b0;
    @(posedge CLK_I); @(negedge CLK_I);
    chk("e5_pulse", e_err, 1'b0);
    chk("e5_idle", e_busy, 1'b0);
    e_ch = 3'd7; e_cv = 1'b1;
    @(posedge CLK_I); @(negedge CLK_I);
    chk("e7_err", e_err, 1'b1);
    e_ch = 3'd4;
    @(posedge CLK_I); @(negedge CLK_I);
    chk("e4_err", e_err, 1'b0);
    chk("e4_busy", e_busy, 1'b1);
    e_cv = 1'b0;
    repeat (G + S + 2) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("e4_done", e_busy, 1'b0);

    cch = 3'd3; cds = 2'b01; cmode = 2'b10; cv = 1'b1;
    step();
    cv = 1'b0;
    repeat (2) step();
    chk("mid_busy", busy, 1'b1);
    RST_I = 1'b1;
    #1 chk_reset_vals("mid");
    @(posedge CLK_I); @(negedge CLK_I);
    RST_I = 1'b0;
    m_reset();
    dov = 8'h5A; oev = 8'hFF;
    repeat (G + S + 2) step();
    chk("post_ds", DS_O, 16'h0000);
    chk("post_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
